// File: rtl/pin_controller.sv
// pin_controller: bus-programmed pin driver (const/PWM); sampling and overflow are built only with PIN_CONTROLLER_RECORD_EN
module pin_controller #(
   parameter logic [7:0] POSITION = 8'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [18:0] cmd_bus_addr,
   input  logic [31:0] cmd_bus_data,
   input  logic        cmd_bus_en,
   input  logic        cmd_bus_rd,
   input  logic        cmd_bus_wr,
   input  logic [31:0] current_time,
   input  logic        pin_in,
   output logic        pin_out,
   output logic        pin_oe,
   output logic [31:0] sample_data,
   output logic        sample_wr_en,
   input  logic        sample_fifo_full,
   output logic        overflow
);
   typedef enum logic [2:0] {IDLE, CONST, PWM_HI, PWM_LO, REC} state_t;
   state_t state, state_n, mode_state;
   logic [31:0] high_cycles, low_cycles, cnt, cnt_n, high_ld, low_ld, rec_ld;
   logic [1:0] mode;
   logic hit, mode_wr, level, unused;
   assign hit = cmd_bus_en & cmd_bus_wr & (cmd_bus_addr[15:8] == POSITION);
   assign mode_wr = hit & (cmd_bus_addr[7:0] == 8'h00);
   assign mode = cmd_bus_data[1:0];
   assign high_ld = (high_cycles == 32'd0) ? 32'd1 : high_cycles;
   assign low_ld = (low_cycles == 32'd0) ? 32'd1 : low_cycles;
`ifdef PIN_CONTROLLER_RECORD_EN
   logic [31:0] sample_div;
   logic sync1, sync2, tick, tick_n;
   assign rec_ld = (sample_div == 32'd0) ? 32'd1 : sample_div;
   assign mode_state = (mode == 2'd3) ? REC : (mode == 2'd2) ? PWM_HI : CONST;
   assign tick_n = (state == REC) & (cnt == 32'd1) & ~mode_wr;
   assign unused = ^{cmd_bus_rd, cmd_bus_addr[18:16], current_time[31]};
   // divider register, written only when recording exists
   always_ff @(posedge clk or posedge rst)
      if (rst) sample_div <= 32'd0;
      else if (hit && cmd_bus_addr[7:0] == 8'h03) sample_div <= cmd_bus_data;
   // pin synchroniser, sample tick pipeline, sample capture and sticky overflow (MODE write clear wins)
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         tick <= 1'b0;
         sample_wr_en <= 1'b0;
         sample_data <= 32'd0;
         overflow <= 1'b0;
      end else begin
         sync1 <= pin_in;
         sync2 <= sync1;
         tick <= tick_n;
         sample_wr_en <= tick & ~sample_fifo_full;
         if (tick && !sample_fifo_full) sample_data <= {current_time[30:0], sync2};
         overflow <= mode_wr ? 1'b0 : (overflow | (tick & sample_fifo_full));
      end
`else
   assign rec_ld = 32'd0;
   assign mode_state = (mode == 2'd2) ? PWM_HI : CONST;
   assign unused = ^{cmd_bus_rd, cmd_bus_addr[18:16], current_time, pin_in, sample_fifo_full};
   assign sample_data = 32'd0;
   assign sample_wr_en = 1'b0;
   assign overflow = 1'b0;
`endif
   // register file and constant level, captured on the hit edge
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         high_cycles <= 32'd0;
         low_cycles <= 32'd0;
         level <= 1'b0;
      end else if (hit) begin
         if (cmd_bus_addr[7:0] == 8'h00) level <= (mode == 2'd1);
         if (cmd_bus_addr[7:0] == 8'h01) high_cycles <= cmd_bus_data;
         if (cmd_bus_addr[7:0] == 8'h02) low_cycles <= cmd_bus_data;
      end
   // state and phase counter registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt <= 32'd0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
      end
   // next state: MODE writes restart, counted states reload only on phase entry
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      if (mode_wr) begin
         state_n = mode_state;
         cnt_n = (mode_state == PWM_HI) ? high_ld : (mode_state == REC) ? rec_ld : 32'd0;
      end else if (state == PWM_HI || state == PWM_LO || state == REC) begin
         state_n = (cnt != 32'd1) ? state : (state == PWM_HI) ? PWM_LO : (state == PWM_LO) ? PWM_HI : REC;
         cnt_n = (cnt != 32'd1) ? cnt - 32'd1 : (state == PWM_HI) ? low_ld : (state == PWM_LO) ? high_ld : rec_ld;
      end
   end
   // registered pin drive, one clock behind the state
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pin_out <= 1'b0;
         pin_oe <= 1'b0;
      end else begin
         pin_out <= (state == PWM_HI) | ((state == CONST) & level);
         pin_oe <= (state == CONST) | (state == PWM_HI) | (state == PWM_LO);
      end
endmodule

// File: doc/pin_controller.md
PIN_CONTROLLER -- requirements
Module: pin_controller

Interface
REQ-001 SHALL have parameter POSITION, default 8'd0, the bus address page this controller answers on (matched against cmd_bus_addr[15:8]).
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports cmd_bus_addr input 19, cmd_bus_data input 32, cmd_bus_en input 1, cmd_bus_rd input 1, cmd_bus_wr input 1, which form the scheduler command bus.
REQ-005 SHALL have ports current_time input 32 (free-running timer) and pin_in input 1 (asynchronous external pin level).
REQ-006 SHALL have ports pin_out output 1 (driven level) and pin_oe output 1 (1 = drive, 0 = high-Z).
REQ-007 SHALL have ports sample_data output 32, sample_wr_en output 1, sample_fifo_full input 1, overflow output 1 (sticky sample-loss flag).

Function
REQ-008 SHALL decode a write hit as cmd_bus_en & cmd_bus_wr & (cmd_bus_addr[15:8]==POSITION), with register index cmd_bus_addr[7:0]; cmd_bus_rd and cmd_bus_addr[18:16] are ignored.
REQ-009 SHALL capture cmd_bus_data on the rising edge where a hit is sampled, with no wait state: 0x00 MODE[1:0], 0x01 HIGH_CYCLES, 0x02 LOW_CYCLES, 0x03 SAMPLE_DIV; writes to other indices are ignored.
REQ-010 SHALL use these MODE encodings: 0 = CONST_LOW, 1 = CONST_HIGH, 2 = PWM, 3 = RECORD.
REQ-011 SHALL implement states IDLE (unarmed, reset state), CONST, PWM_HI, PWM_LO, REC.
REQ-012 SHALL, on any MODE write sampled at edge E, leave the current state and present the new mode's first output from edge E+1 (CONST, PWM_HI or REC); a PWM MODE write restarts the pattern at PWM_HI.
REQ-013 SHALL, in PWM, hold pin_out=1 for exactly max(HIGH_CYCLES,1) clocks, then 0 for max(LOW_CYCLES,1) clocks, and repeat.
REQ-014 SHALL reload the phase counter from HIGH_CYCLES/LOW_CYCLES only at phase entry, so that writes to these registers mid-phase take effect at the next phase entry.
REQ-015 SHALL handle counter arithmetic as 32-bit unsigned down-count to 1; a value of 0xFFFFFFFF SHALL be honoured without wrap.
REQ-016 SHALL drive pin_oe=1 in CONST/PWM states, and pin_oe=0 in IDLE and REC.
REQ-017 SHALL synchronise pin_in through two flops before any use.
REQ-018 SHALL, in REC, pulse sample_wr_en for one clock every max(SAMPLE_DIV,1) clocks, the first pulse occurring max(SAMPLE_DIV,1) clocks after REC entry, with sample_data={current_time[30:0], synced pin_in}.
REQ-019 SHALL, when sample_fifo_full=1 at a sample tick, suppress sample_wr_en, drop the sample, set overflow, and keep the divider running.
REQ-020 SHALL clear overflow on any MODE write; if a set condition and a clear occur on the same edge, the clear wins.
REQ-021 SHALL register all outputs, with sample_data holding its last value between pulses.

Reset
REQ-022 SHALL, on rst asserted (asynchronous, any cycle including mid-PWM or mid-REC), immediately force state IDLE, all registers to 0, pin_out=0, pin_oe=0, sample_wr_en=0, sample_data=0, overflow=0, and synchroniser flops to 0.
REQ-023 SHALL remain in IDLE after rst deasserts until the first MODE write.

Configuration
REQ-024 SHALL, with PIN_CONTROLLER_RECORD_EN defined, implement REC, the synchroniser, the sampling divider, and overflow as specified.
REQ-025 SHALL, without PIN_CONTROLLER_RECORD_EN, decode MODE=3 as CONST_LOW, ignore writes to 0x03, and tie sample_wr_en=0, sample_data=0, overflow=0.

Verification
REQ-026 SHALL cover: reset, then POSITION=5 with a write addr 0x0500 data 1 -> pin_oe=1 and pin_out=1 from the next edge; the same write to addr 0x0600 -> no change.
REQ-027 SHALL cover: HIGH=3, LOW=2, MODE=2 -> pin_out pattern 1,1,1,0,0 repeating, with the first 1 at the edge after the MODE write.
REQ-028 SHALL cover: in PWM, write HIGH=0 and LOW=0 mid-high-phase -> the current phase completes, then pin_out toggles every clock.
REQ-029 SHALL cover: SAMPLE_DIV=4, MODE=3, pin_in held 1 -> one sample_wr_en every 4 clocks, with sample_data[0]=1 and sample_data[31:1]=current_time[30:0].
REQ-030 SHALL cover: in REC with sample_fifo_full=1 across one tick -> no pulse and overflow=1; a subsequent MODE write -> overflow=0 on the next edge.
REQ-031 SHALL cover: rst pulsed mid-PWM with pin_out=1 -> pin_out=0 and pin_oe=0 without waiting for a clock edge, and the block stays IDLE after release.
